// File: rtl/chaos_sync_checker_pkg.sv
// Shared definitions for the quadratic-map chaos stream: map constants and
// the checker FSM state encoding.
package chaos_pkg;

  localparam logic signed [15:0] CHAOS_SEED = 16'sh7EF0;
  localparam logic signed [15:0] CHAOS_ONE  = 16'sh7FFF;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } state_t;

endpackage

// File: rtl/chaos_sync_checker_if.sv
// Stream and status bundle between the link receiver and the sync checker.
interface chaos_sync_checker_if #(
  parameter int unsigned ERR_W = 16
) ();

  logic              in_valid;
  logic [15:0]       in_data;
  logic              clear_cnt;
  logic              locked;
  logic              match_pulse;
  logic              err_pulse;
  logic [ERR_W-1:0]  err_count;
  logic [15:0]       pred_out;

  modport master (
    output in_valid, in_data, clear_cnt,
    input  locked, match_pulse, err_pulse, err_count, pred_out
  );

  modport slave (
    input  in_valid, in_data, clear_cnt,
    output locked, match_pulse, err_pulse, err_count, pred_out
  );

endinterface

// File: rtl/quadratic_step.sv
// One iteration of the quadratic chaos map, f(x) = 1 - 4x^2 in Q1.15,
// bit-exact with the generator.
module quadratic_step
  import chaos_pkg::*;
(
  input  logic signed [15:0] x,
  output logic signed [15:0] y
);

  logic signed [28:0] xe;
  logic signed [28:0] sq;

  // Bits [30:15] of (x*x)<<<2 are bits [28:13] of x*x, so only the low
  // 29 bits of the square are ever needed.
  always_comb begin
    xe = 29'(x);
    sq = xe * xe;
    y  = CHAOS_ONE - 16'(sq >> 13);
  end

endmodule

// File: rtl/chaos_sync_checker.sv
// Self-synchronising receive-side checker: seeds a local copy of the map from
// the stream, verifies predictions, locks, and counts mismatches while locked.
module chaos_sync_checker
  import chaos_pkg::*;
#(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3,
  parameter int unsigned ERR_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  chaos_sync_checker_if.slave bus
);

  state_t             state, state_nxt;
  logic signed [15:0] pred, pred_nxt;
  logic signed [15:0] f_in, f_pred;
  logic [7:0]         match_cnt, match_cnt_nxt;
  logic [7:0]         miss_cnt, miss_cnt_nxt;
  logic               hit, match_now, err_now;
  logic               locked_q, match_q, err_q;
  logic [ERR_W-1:0]   err_count;

  quadratic_step u_step_in   (.x(bus.in_data), .y(f_in));
  quadratic_step u_step_pred (.x(pred),        .y(f_pred));

  assign hit = (bus.in_data == pred);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= HUNT;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.in_valid) begin
      unique case (state)
        HUNT:    state_nxt = VERIFY;
        VERIFY:  if (hit && (match_cnt + 8'd1 == 8'(LOCK_CNT))) state_nxt = LOCK;
        LOCK:    if (!hit && (miss_cnt + 8'd1 == 8'(LOSS_CNT))) state_nxt = HUNT;
        default: state_nxt = HUNT;
      endcase
    end
  end

  always_comb begin
    match_now     = 1'b0;
    err_now       = 1'b0;
    pred_nxt      = pred;
    match_cnt_nxt = match_cnt;
    miss_cnt_nxt  = miss_cnt;
    if (bus.in_valid) begin
      unique case (state)
        HUNT: begin
          pred_nxt      = f_in;
          match_cnt_nxt = '0;
        end
        VERIFY: begin
          pred_nxt = f_in;
          if (hit) begin
            match_now     = 1'b1;
            match_cnt_nxt = match_cnt + 8'd1;
          end else begin
            match_cnt_nxt = '0;
          end
          if (state_nxt == LOCK) miss_cnt_nxt = '0;
        end
        LOCK: begin
          if (hit) begin
            match_now    = 1'b1;
            pred_nxt     = f_in;
            miss_cnt_nxt = '0;
          end else begin
            // Flywheel: a corrupted sample must never reseed the prediction.
            err_now      = 1'b1;
            pred_nxt     = f_pred;
            miss_cnt_nxt = miss_cnt + 8'd1;
          end
        end
        default: pred_nxt = pred;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pred      <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked_q  <= 1'b0;
      match_q   <= 1'b0;
      err_q     <= 1'b0;
      err_count <= '0;
    end else begin
      pred      <= pred_nxt;
      match_cnt <= match_cnt_nxt;
      miss_cnt  <= miss_cnt_nxt;
      locked_q  <= (state_nxt == LOCK);
      match_q   <= match_now;
      err_q     <= err_now;
      if (bus.clear_cnt)               err_count <= '0;
      else if (err_now && !(&err_count)) err_count <= err_count + 1'b1;
    end
  end

  assign bus.locked      = locked_q;
  assign bus.match_pulse = match_q;
  assign bus.err_pulse   = err_q;
  assign bus.err_count   = err_count;
  assign bus.pred_out    = pred;

endmodule

// File: doc/chaos_sync_checker.md
Name: chaos_sync_checker

Overview:
- Receive-side consumer of the 16-bit quadratic-map chaotic sample stream produced by the generator block.
- Self-synchronises to the incoming stream by seeding a local copy of the map with a received sample.
- Predicts every following sample and declares lock after consecutive matches; drops lock after consecutive misses.
- Counts mismatches while locked; used on the far end of the link to confirm the key stream before decryption.

Parameters:
LOCK_CNT, 4, consecutive matches in VERIFY required to enter LOCK (1..255)
LOSS_CNT, 3, consecutive mismatches in LOCK that force return to HUNT (1..255)
ERR_W, 16, width of saturating error counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
in_valid  input  1  in_data carries a sample this cycle
in_data  input  16  received sample, signed Q1.15
clear_cnt  input  1  synchronous clear of err_count
locked  output  1  high while FSM in LOCK
match_pulse  output  1  one-cycle pulse: compared sample matched prediction
err_pulse  output  1  one-cycle pulse: compared sample mismatched while in LOCK
err_count  output  ERR_W  saturating count of LOCK mismatches
pred_out  output  16  current prediction register (next expected sample)

Behaviour:
- Map f(x), all signed: sq = x*x (32 bit); m = sq <<< 2 (32 bit, overflow discarded); f(x) = 16'sh7FFF - m[30:15], 16-bit wrap. This is bit-exact with the generator; f(16'sh7EF0) = 16'h8876.
- Reset (rst low, asynchronous): state=HUNT, pred=0, match_cnt=0, miss_cnt=0, locked=0, match_pulse=0, err_pulse=0, err_count=0.
- All outputs are registered. The result of a sample accepted at edge N is visible after edge N+1. Cycles with in_valid=0 change nothing except clear_cnt.
- HUNT: on in_valid, pred<=f(in_data), match_cnt<=0, go to VERIFY. No pulses.
- VERIFY:
  - On in_valid with in_data==pred: match_pulse=1, pred<=f(in_data), match_cnt++. When match_cnt reaches LOCK_CNT, go to LOCK with miss_cnt<=0 and locked=1 from the next cycle.
  - On mismatch: reseed pred<=f(in_data), match_cnt<=0, stay in VERIFY. No err_pulse and no err_count change.
- LOCK:
  - Match: match_pulse=1, pred<=f(in_data), miss_cnt<=0.
  - Mismatch: err_pulse=1, err_count++ (saturates at all-ones), miss_cnt++, flywheel pred<=f(pred) (the received value is never used to reseed).
  - When miss_cnt reaches LOSS_CNT, go to HUNT and deassert locked. That final mismatch is still counted and pulsed.
- clear_cnt: err_count<=0. If clear_cnt and a counted mismatch occur in the same cycle, clear wins (result 0).
- rst asserted mid-stream returns to HUNT immediately. The first valid sample after release is always treated as a seed.
- Pulses are high for exactly one cycle per accepted sample; both pulses are never high in the same cycle.

Decomposition:
- Shared package chaos_pkg:
  - CHAOS_SEED = 16'sh7EF0
  - CHAOS_ONE = 16'sh7FFF
  - 2-bit state enum {HUNT, VERIFY, LOCK}
- Sub-module quadratic_step: purely combinational f(x), 16 in / 16 out, reusable by the generator. Two instances, one on in_data and one on pred.

Test Plan:
- Reset then feed a reference-model stream starting 16'h7EF0, 16'h8876, … (5 valid samples) -> locked=1 after the 5th sample's edge+1, match_pulse on samples 2–5, err_count=0.
- While locked, corrupt one sample (xor 16'h0001) then resume the true stream -> exactly one err_pulse, err_count=1, locked stays 1, following samples match because of the flywheel prediction.
- While locked, feed 3 consecutive garbage samples -> err_count=3, locked drops after the 3rd, state=HUNT; resume the stream -> relock after 5 more samples.
- In VERIFY, inject a mismatch at match 2 of 4 -> match_cnt restarts, lock is delayed by the reseed, err_count unchanged.
- Assert clear_cnt in the same cycle as a locked mismatch -> err_count=0 next cycle, err_pulse still 1.
- Drive in_valid with gaps of 0–3 idle cycles, and assert rst mid-VERIFY -> state and pred are unchanged across idle cycles; reset gives locked=0, err_count=0, pred=0 asynchronously.
